// File: rtl/uart_mon_pkg.sv
// rtl/uart_mon_pkg.sv - shared types and constants for the serial receive monitor
package uart_mon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } mon_state_e;

  localparam int UART_DATA_W    = 8;
  localparam int UART_STOP_BITS = 1;

endpackage

// File: rtl/mon_sync_fifo.sv
// rtl/mon_sync_fifo.sv - synchronous FIFO with pointer-MSB full/empty and push-while-full-and-popping
module mon_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop   = pop & ~empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push  = push & (~full | do_pop);
  assign level    = wr_q - rd_q;
  assign pop_data = mem_q[rd_q[AW-1:0]];

  // Next pointers and storage contents for this cycle's push/pop.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = push_data;
      wr_d = wr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + (AW+1)'(1);
    end
  end

  // Storage and pointer registers; reset clears entries so the head reads 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '{default: '0};
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/uart_rx_monitor.sv
// rtl/uart_rx_monitor.sv - 8N1 deframer with input synchronizer, baud counter and receive FIFO
module uart_rx_monitor
  import uart_mon_pkg::*;
#(
  parameter int DIV_RATE   = 260,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  input  logic                          rd_ready,
  output logic                          rd_valid,
  output logic [UART_DATA_W-1:0]        rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_err,
  output logic [7:0]                    ovf_cnt,
  output logic                          busy
);
  localparam int              CW        = $clog2(DIV_RATE);
  localparam logic [CW-1:0]   HALF_M1   = CW'(DIV_RATE / 2 - 1);
  localparam logic [CW-1:0]   FULL_M1   = CW'(DIV_RATE - 1);
  localparam logic [2:0]      LAST_DATA = 3'(UART_DATA_W - 1);
  localparam logic [2:0]      LAST_STOP = 3'(UART_STOP_BITS - 1);

  logic       sync1_q, sync1_d, sync2_q, sync2_d, rx_dly_q, rx_dly_d;
  logic       arm_q, arm_d;
  logic [1:0] fill_q, fill_d;
  logic       rx_s, fall;

  mon_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   ferr_q, ferr_d;
  logic                   busy_q, busy_d;
  logic [7:0]             ovf_q, ovf_d;
  logic                   push;

  logic fifo_full, fifo_empty, pop;

  // Synchronizer chain; edge detection is armed only once a genuine high has
  // propagated through it, so a line still low after reset is not a start bit.
  always_comb begin
    sync1_d  = rx;
    sync2_d  = sync1_q;
    rx_dly_d = sync2_q;
    fill_d   = {fill_q[0], 1'b1};
    arm_d    = arm_q | (fill_q[1] & sync2_q);
  end

  // Synchronizer registers, idle-high after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      rx_dly_q <= 1'b1;
      fill_q   <= '0;
      arm_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      rx_dly_q <= rx_dly_d;
      fill_q   <= fill_d;
      arm_q    <= arm_d;
    end
  end

  assign rx_s = sync2_q;
  assign fall = arm_q & rx_dly_q & ~rx_s;

  // Deframing FSM next state: counter restarts from 0 on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == FULL_M1) ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    ferr_d  = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          shift_d[idx_q] = rx_s;
          if (idx_q == LAST_DATA) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (!rx_s) begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end else if (idx_q == LAST_STOP) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Deframing FSM registers with registered busy and frame_err outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign pop = rd_ready & ~fifo_empty;

  // Dropped-character counter, saturating.
  always_comb begin
    ovf_d = ovf_q;
    if (push && fifo_full && !pop && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end
  end

  // Dropped-character counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  mon_sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (shift_q),
    .pop       (pop),
    .pop_data  (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign rd_valid  = ~fifo_empty;
  assign frame_err = ferr_q;
  assign busy      = busy_q;
  assign ovf_cnt   = ovf_q;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb/tb_uart_rx_monitor.sv - self-checking bench for uart_rx_monitor
module tb_uart_rx_monitor;
  localparam int DIV   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rd_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [2:0] fifo_level;
  logic       frame_err;
  logic [7:0] ovf_cnt;
  logic       busy;

  uart_rx_monitor #(
    .DIV_RATE   (DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .fifo_level (fifo_level),
    .frame_err  (frame_err),
    .ovf_cnt    (ovf_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] model_q[$];
  logic [7:0] exp_pop_q[$];
  logic [7:0] got_q[$];
  int         pop_chk = 0;
  int         ferr_cnt = 0;
  int         ferr_base, ferr_exp, ovf_exp, lat;
  logic [7:0] b;
  logic       ok;

  // Observe pops and frame_err cycles away from the active edge.
  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (rd_valid && rd_ready && !reset) got_q.push_back(rd_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_ok);
    logic [9:0] bits;
    bits = {stop_ok, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (DIV) tick();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_level"}, fifo_level, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_ovf"}, ovf_cnt, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic drain();
    rd_ready = 1'b1;
    repeat (DEPTH + 2) tick();
    rd_ready = 1'b0;
    while (model_q.size() > 0) exp_pop_q.push_back(model_q.pop_front());
    @(negedge clk);
    check("drain_empty", rd_valid, 0);
    tick();
  endtask

  task automatic cmp_pops(input string tag);
    check({tag, "_pop_count"}, got_q.size(), exp_pop_q.size());
    for (int i = pop_chk; i < exp_pop_q.size() && i < got_q.size(); i++)
      check({tag, "_pop_data"}, got_q[i], exp_pop_q[i]);
    pop_chk = exp_pop_q.size();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    rx       = 1'b1;
    rd_ready = 1'b0;
    ovf_exp  = 0;
    repeat (3) tick();
    reset = 1'b0;
    check_reset_vals("reset");
    repeat (5) tick();

    // Single frame: latency from first low to rd_valid.
    ferr_base = ferr_cnt;
    lat = 0;
    fork
      send_frame(8'h55, 1'b1);
      begin
        for (lat = 0; lat < 400; lat++) begin
          @(negedge clk);
          if (rd_valid) break;
        end
      end
    join
    model_q.push_back(8'h55);
    check("single_latency", lat, 2 + DIV / 2 + 9 * DIV + 1);
    check("single_data", rd_data, 8'h55);
    check("single_level", fifo_level, 1);
    check("single_no_ferr", ferr_cnt - ferr_base, 0);
    drain();
    cmp_pops("single");

    // Glitch: short low pulse is rejected at the start-bit sample.
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy) break;
    end
    check("glitch_busy_rise", busy, 1);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("glitch_busy_fall", busy, 0);
    check("glitch_level", fifo_level, 0);
    repeat (5) tick();

    // Framing error followed by a held-low line, then a clean frame.
    ferr_base = ferr_cnt;
    send_frame(8'hA3, 1'b0);
    repeat (40) tick();
    rx = 1'b1;
    repeat (20) tick();
    check("ferr_nothing_pushed", fifo_level, 0);
    send_frame(8'h3C, 1'b1);
    model_q.push_back(8'h3C);
    repeat (10) tick();
    @(negedge clk);
    check("ferr_pulse_count", ferr_cnt - ferr_base, 1);
    check("ferr_then_level", fifo_level, 1);
    check("ferr_then_data", rd_data, 8'h3C);
    drain();
    cmp_pops("ferr");

    // Randomized frames with continuous consumer; some have bad stop bits.
    rd_ready  = 1'b1;
    ferr_base = ferr_cnt;
    ferr_exp  = 0;
    for (int n = 0; n < 12; n++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      send_frame(b, ok);
      if (ok) begin
        exp_pop_q.push_back(b);
      end else begin
        ferr_exp++;
        repeat ($urandom_range(0, 30)) tick();
      end
      rx = 1'b1;
      if (ok) repeat ($urandom_range(0, 4)) tick();
      else    repeat ($urandom_range(2, 10)) tick();
    end
    repeat (40) tick();
    rd_ready = 1'b0;
    @(negedge clk);
    check("rand_ferr", ferr_cnt - ferr_base, ferr_exp);
    check("rand_level", fifo_level, 0);
    cmp_pops("rand");
    tick();

    // Overflow: six back-to-back frames into a depth-4 FIFO.
    for (int n = 1; n <= 6; n++) begin
      send_frame(8'(n), 1'b1);
      if (model_q.size() < DEPTH) model_q.push_back(8'(n));
      else if (ovf_exp < 255) ovf_exp++;
    end
    repeat (5) tick();
    @(negedge clk);
    check("ovf_level", fifo_level, DEPTH);
    check("ovf_count", ovf_cnt, ovf_exp);
    check("ovf_head", rd_data, model_q[0]);

    // Full FIFO with a pop coinciding with the stop-sample push.
    b = 8'($urandom);
    fork
      send_frame(b, 1'b1);
      begin
        repeat (2 + DIV / 2 + 9 * DIV) tick();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
      end
    join
    exp_pop_q.push_back(model_q.pop_front());
    model_q.push_back(b);
    repeat (3) tick();
    @(negedge clk);
    check("fullpop_level", fifo_level, DEPTH);
    check("fullpop_ovf", ovf_cnt, ovf_exp);
    check("fullpop_head", rd_data, model_q[0]);
    cmp_pops("fullpop");

    // Reset during data bit 3 of an all-zero frame; FIFO is full beforehand.
    ferr_base = ferr_cnt;
    fork
      send_frame(8'h00, 1'b1);
      begin
        repeat (4 * DIV + 8) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        check_reset_vals("midreset");
      end
    join
    model_q.delete();
    repeat (20) tick();
    @(negedge clk);
    check("midreset_no_restart_busy", busy, 0);
    check("midreset_no_restart_level", fifo_level, 0);
    check("midreset_no_ferr", ferr_cnt - ferr_base, 0);
    send_frame(8'h7E, 1'b1);
    model_q.push_back(8'h7E);
    repeat (10) tick();
    @(negedge clk);
    check("post_reset_level", fifo_level, 1);
    check("post_reset_data", rd_data, 8'h7E);
    drain();
    cmp_pops("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
